// File: rtl/gpio_debounce.sv
// Per-bit debouncer for board buttons and switches: a 2-flop synchroniser into clk_16M, then a
// qualification counter that publishes a new level only after it has held for STABLE_CYCLES cycles.
module gpio_debounce #(
    parameter int               WIDTH         = 11,
    parameter int               STABLE_CYCLES = 160000,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}},
    parameter int               CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic             clk_16M,
    input  logic             reset_periph,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] deb_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             event_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt   [WIDTH];
    logic [CNT_W-1:0] cnt_n [WIDTH];
    logic [WIDTH-1:0] deb_n;
    logic [WIDTH-1:0] rise_n;
    logic [WIDTH-1:0] fall_n;

    // Any return to the published level clears the count, so qualification needs an unbroken run.
    always_comb begin
        deb_n  = deb_o;
        rise_n = '0;
        fall_n = '0;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_n[b] = '0;
            if (s2[b] != deb_o[b]) begin
                if (cnt[b] == CNT_MAX) begin
                    deb_n[b]  = s2[b];
                    rise_n[b] = s2[b];
                    fall_n[b] = ~s2[b];
                end else begin
                    cnt_n[b] = cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_16M) begin
        if (reset_periph) begin
            s1      <= RESET_VAL;
            s2      <= RESET_VAL;
            deb_o   <= RESET_VAL;
            rise_o  <= '0;
            fall_o  <= '0;
            event_o <= 1'b0;
            for (int b = 0; b < WIDTH; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            s1      <= pad_i;
            s2      <= s1;
            deb_o   <= deb_n;
            rise_o  <= rise_n;
            fall_o  <= fall_n;
            event_o <= |(rise_n | fall_n);
            for (int b = 0; b < WIDTH; b++) begin
                cnt[b] <= cnt_n[b];
            end
        end
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: a sample-history reference model fills an expected queue each cycle,
// plus directed latency/pulse checks for reset, press, bounce, glitch, simultaneous and mid-reset cases.
module tb_gpio_debounce;

    localparam int               WIDTH = 4;
    localparam int               SC    = 4;
    localparam logic [WIDTH-1:0] RV    = '0;
    localparam int               OW    = 3 * WIDTH + 1;

    logic             clk_16M = 1'b0;
    logic             reset_periph = 1'b1;
    logic [WIDTH-1:0] pad_i = '0;
    logic [WIDTH-1:0] deb_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             event_o;

    // clock / reset
    always #5 clk_16M = ~clk_16M;

    gpio_debounce #(
        .WIDTH(WIDTH),
        .STABLE_CYCLES(SC),
        .RESET_VAL(RV)
    ) dut (
        .clk_16M(clk_16M),
        .reset_periph(reset_periph),
        .pad_i(pad_i),
        .deb_o(deb_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .event_o(event_o)
    );

    int               checks = 0;
    int               errors = 0;
    logic [OW-1:0]    exp_q[$];
    logic [WIDTH-1:0] hist [SC+2];
    logic [WIDTH-1:0] m_deb = RV;
    int               age = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // hist[0] is the level captured by s1 at this edge; a bit flips when the STABLE_CYCLES samples
    // ending two edges back all differ from the published level, with no reset inside that span.
    task automatic model_step(input logic [WIDTH-1:0] pad, input logic rst);
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic             ok;
        for (int j = SC + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = rst ? RV : pad;
        rise = '0;
        fall = '0;
        if (rst) begin
            age   = 0;
            m_deb = RV;
        end else begin
            age++;
            for (int b = 0; b < WIDTH; b++) begin
                ok = (age >= SC + 1);
                for (int j = 2; j < SC + 2; j++) begin
                    if (hist[j][b] == m_deb[b]) ok = 1'b0;
                end
                if (ok) begin
                    if (m_deb[b]) fall[b] = 1'b1;
                    else          rise[b] = 1'b1;
                    m_deb[b] = ~m_deb[b];
                end
            end
        end
        exp_q.push_back({m_deb, rise, fall, |(rise | fall)});
    endtask

    task automatic tick(input string tag, input logic [WIDTH-1:0] pad, input logic rst);
        logic [OW-1:0] e;
        pad_i        = pad;
        reset_periph = rst;
        model_step(pad, rst);
        @(posedge clk_16M);
        #1;
        e = exp_q.pop_front();
        check(tag, 32'({deb_o, rise_o, fall_o, event_o}), 32'(e));
    endtask

    // Holds pad for n cycles; checks which cycle (1-based) produced the first event, and the outputs then.
    task automatic run(input string tag, input logic [WIDTH-1:0] pad, input int n,
                       input int exp_lat, input logic [OW-1:0] exp_snap);
        int            lat;
        logic [OW-1:0] snap;
        lat  = 0;
        snap = '0;
        for (int i = 1; i <= n; i++) begin
            tick(tag, pad, 1'b0);
            if (event_o && lat == 0) begin
                lat  = i;
                snap = {deb_o, rise_o, fall_o, event_o};
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out"}, 32'(snap), 32'(exp_snap));
    endtask

    initial begin
        for (int j = 0; j < SC + 2; j++) hist[j] = RV;

        // reset held with all pads high, then accepted on the 6th edge (5 after first sampling edge)
        for (int i = 0; i < 3; i++) tick("rst_hold", 4'hF, 1'b1);
        run("rst", 4'hF, 8, 6, {4'hF, 4'hF, 4'h0, 1'b1});

        // clean press on bit 0
        for (int i = 0; i < 2; i++) tick("rst2", 4'h0, 1'b1);
        run("press", 4'h1, 8, 6, {4'h1, 4'h1, 4'h0, 1'b1});

        // bounce on bit 1: 1,0,1,0 then hold 1
        tick("bounce", 4'h3, 1'b0);
        tick("bounce", 4'h1, 1'b0);
        tick("bounce", 4'h3, 1'b0);
        tick("bounce", 4'h1, 1'b0);
        run("bounce_hold", 4'h3, 10, 6, {4'h3, 4'h2, 4'h0, 1'b1});

        // three-cycle glitch on bit 2 is rejected
        for (int i = 0; i < 3; i++) tick("glitch", 4'h7, 1'b0);
        run("glitch_after", 4'h3, 10, 0, '0);

        // bit 0 falls and bit 3 rises on the same edge
        run("simul", 4'hA, 8, 6, {4'hA, 4'h8, 4'h1, 1'b1});

        // reset two cycles into a bit-0 qualification
        for (int i = 0; i < 2; i++) tick("rst3", 4'h0, 1'b1);
        tick("mrst_pre", 4'h1, 1'b0);
        tick("mrst_pre", 4'h1, 1'b0);
        tick("mrst_rst", 4'h1, 1'b1);
        run("mrst", 4'h1, 8, 6, {4'h1, 4'h1, 4'h0, 1'b1});

        // random pad activity with occasional resets, checked against the model every cycle
        begin
            logic [WIDTH-1:0] p;
            p = '0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 5) == 0) p = WIDTH'($urandom_range(0, 15));
                tick("rand", p, ($urandom_range(0, 99) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
